// File: rtl/packet_scheduler_if.sv
// Packet ingress / egress bus of the packet scheduler.
// The master side drives packets and read requests; the slave side returns served packets.
interface packet_scheduler_if #(
    parameter int DW = 4
);
    logic          in_valid;
    logic [1:0]    in_id;
    logic [DW-1:0] in_data;
    logic          rd_req;
    logic          out_valid;
    logic [1:0]    out_id;
    logic [DW-1:0] out_data;

    modport master (
        output in_valid, in_id, in_data, rd_req,
        input  out_valid, out_id, out_data
    );

    modport slave (
        input  in_valid, in_id, in_data, rd_req,
        output out_valid, out_id, out_data
    );
endinterface

// File: rtl/packet_scheduler.sv
// Four circular packet FIFOs drained one packet per request by a round-robin IDLE/SEL/OUT FSM,
// with saturating receive/transmit/drop statistics and a combinational slot display port.
module packet_scheduler #(
    parameter int DEPTH = 6,
    parameter int DW    = 4,
    parameter int CW    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    packet_scheduler_if.slave    bus,
    output logic                 busy,
    output logic [11:0]          occ,
    output logic [CW-1:0]        rcv_cnt,
    output logic [CW-1:0]        trn_cnt,
    output logic [CW-1:0]        drp_cnt,
    input  logic [1:0]           disp_buf,
    input  logic [2:0]           disp_slot,
    output logic [DW-1:0]        disp_data,
    output logic                 disp_full
);
    localparam logic [1:0]    IDLE = 2'd0;
    localparam logic [1:0]    SEL  = 2'd1;
    localparam logic [1:0]    OUT  = 2'd2;

    localparam logic [2:0]    DEPTH3 = 3'(DEPTH);
    localparam logic [3:0]    DEPTH4 = 4'(DEPTH);
    localparam logic [2:0]    LAST   = 3'(DEPTH - 1);
    localparam logic [CW-1:0] CMAX   = '1;

    logic [DW-1:0] mem [4][DEPTH];
    logic [2:0]    rd_ptr [4];
    logic [2:0]    wr_ptr [4];
    logic [2:0]    cnt    [4];

    logic [1:0]    state;
    logic [1:0]    last_grant;
    logic [1:0]    grant;
    logic          grant_vld;
    logic [3:0]    push;
    logic [3:0]    pop;
    logic          drop;

    logic          out_valid_q;
    logic [1:0]    out_id_q;
    logic [DW-1:0] out_data_q;

    function automatic logic [2:0] nxt(input logic [2:0] p);
        return (p == LAST) ? 3'd0 : p + 3'd1;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == CMAX) ? c : c + 1'b1;
    endfunction

    // Round-robin: first non-empty FIFO strictly after the last one served.
    always_comb begin
        logic [1:0] idx;
        idx       = '0;
        grant     = '0;
        grant_vld = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_grant + 2'(i);
            if (!grant_vld && cnt[idx] != 3'd0) begin
                grant     = idx;
                grant_vld = 1'b1;
            end
        end
    end

    // Fullness is judged on start-of-cycle occupancy, so a same-cycle pop never makes room.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            push[b] = bus.in_valid && (bus.in_id == 2'(b)) && (cnt[b] < DEPTH3);
            pop[b]  = (state == SEL) && grant_vld && (grant == 2'(b));
        end
        drop = bus.in_valid && (cnt[bus.in_id] >= DEPTH3);
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (push[b]) mem[b][wr_ptr[b]] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 4; b++) begin
                rd_ptr[b] <= '0;
                wr_ptr[b] <= '0;
                cnt[b]    <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (push[b]) wr_ptr[b] <= nxt(wr_ptr[b]);
                if (pop[b])  rd_ptr[b] <= nxt(rd_ptr[b]);
                cnt[b] <= cnt[b] + 3'(push[b]) - 3'(pop[b]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rcv_cnt <= '0;
            trn_cnt <= '0;
            drp_cnt <= '0;
        end else begin
            if (|push)       rcv_cnt <= sat_inc(rcv_cnt);
            if (|pop)        trn_cnt <= sat_inc(trn_cnt);
            if (drop)        drp_cnt <= sat_inc(drp_cnt);
        end
    end

    // The pulse is registered out of OUT, so a reset while in OUT suppresses it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= 2'd3;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= (state == OUT);
            case (state)
                IDLE: if (bus.rd_req) state <= SEL;
                SEL: begin
                    if (grant_vld) begin
                        out_id_q   <= grant;
                        out_data_q <= mem[grant][rd_ptr[grant]];
                        last_grant <= grant;
                        state      <= OUT;
                    end else begin
                        state <= IDLE;
                    end
                end
                OUT:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_id    = out_id_q;
    assign bus.out_data  = out_data_q;
    assign busy          = (state != IDLE);

    for (genvar b = 0; b < 4; b++) begin : g_occ
        assign occ[3*b +: 3] = cnt[b];
    end

    // Slot 0 is the head; offset from the read pointer modulo DEPTH (two folds cover slot 7).
    always_comb begin
        logic [3:0] s;
        s = {1'b0, rd_ptr[disp_buf]} + {1'b0, disp_slot};
        if (s >= DEPTH4) s = s - DEPTH4;
        if (s >= DEPTH4) s = s - DEPTH4;
        disp_data = mem[disp_buf][3'(s)];
        disp_full = (disp_slot < cnt[disp_buf]);
    end
endmodule
